// File: rtl/uart_rx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_packetizer
// Description : Packs UART RX bytes into 29-bit FIFO packets (1-3 bytes each).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_packetizer #(
    parameter int TIMEOUT_CYCLES = 52080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        flush,
    output logic [28:0] pkt_data,
    output logic        pkt_wren,
    input  logic        pkt_full,
    output logic        overflow,
    input  logic        overflow_clr,
    output logic        idle
);

    // A zero timeout still needs a legal one-bit counter; the hit is gated off.
    localparam int               CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic             TMO_EN  = (TIMEOUT_CYCLES > 0);

    logic [1:0]       asm_cnt_q,    asm_cnt_d;
    logic [23:0]      asm_data_q,   asm_data_d;
    logic             out_valid_q,  out_valid_d;
    logic [28:0]      pkt_data_q,   pkt_data_d;
    logic [CNT_W-1:0] tmo_cnt_q,    tmo_cnt_d;
    logic             overflow_q,   overflow_d;
    logic             flush_pend_q, flush_pend_d;

    logic w_partial;
    logic w_slot_free;
    logic w_tmo_hit;
    logic w_flush_req;
    logic w_xfer;
    logic w_drop;

    assign pkt_wren    = out_valid_q & ~pkt_full;
    assign w_slot_free = ~out_valid_q | pkt_wren;
    assign w_partial   = (asm_cnt_q == 2'd1) | (asm_cnt_q == 2'd2);
    assign w_tmo_hit   = TMO_EN & (tmo_cnt_q == TMO_MAX) & w_partial;
    assign w_flush_req = (flush | flush_pend_q) & w_partial;
    assign w_xfer      = w_slot_free & ((asm_cnt_q == 2'd3) | w_tmo_hit | w_flush_req);
    assign w_drop      = byte_valid & (asm_cnt_q == 2'd3) & ~w_xfer;

    always_comb begin
        asm_cnt_d    = asm_cnt_q;
        asm_data_d   = asm_data_q;
        out_valid_d  = out_valid_q;
        pkt_data_d   = pkt_data_q;
        tmo_cnt_d    = tmo_cnt_q;
        flush_pend_d = flush_pend_q;

        if (w_xfer) begin
            pkt_data_d  = {1'b0, asm_cnt_q, 2'b00, asm_data_q};
            out_valid_d = 1'b1;
            asm_cnt_d   = 2'd0;
            asm_data_d  = 24'd0;
        end else if (pkt_wren) begin
            out_valid_d = 1'b0;
        end

        // A byte coinciding with a transfer lands in the just-emptied register.
        if (byte_valid) begin
            if (w_xfer) begin
                asm_data_d = {16'd0, byte_data};
                asm_cnt_d  = 2'd1;
            end else if (asm_cnt_q != 2'd3) begin
                case (asm_cnt_q)
                    2'd0:    asm_data_d[7:0]   = byte_data;
                    2'd1:    asm_data_d[15:8]  = byte_data;
                    default: asm_data_d[23:16] = byte_data;
                endcase
                asm_cnt_d = asm_cnt_q + 2'd1;
            end
        end

        if (byte_valid || (asm_cnt_q == 2'd0)) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end

        if (w_xfer || byte_valid) begin
            flush_pend_d = 1'b0;
        end else if (flush && (asm_cnt_q != 2'd0)) begin
            flush_pend_d = 1'b1;
        end

        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_cnt_q    <= 2'd0;
            asm_data_q   <= 24'd0;
            out_valid_q  <= 1'b0;
            pkt_data_q   <= 29'd0;
            tmo_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            asm_cnt_q    <= asm_cnt_d;
            asm_data_q   <= asm_data_d;
            out_valid_q  <= out_valid_d;
            pkt_data_q   <= pkt_data_d;
            tmo_cnt_q    <= tmo_cnt_d;
            overflow_q   <= overflow_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign pkt_data = pkt_data_q;
    assign overflow = overflow_q;
    assign idle     = (asm_cnt_q == 2'd0) & ~out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_packetizer
// Description : Directed and randomized bench with a byte-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_packetizer;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        flush;
    logic [28:0] pkt_data;
    logic        pkt_wren;
    logic        pkt_full;
    logic        overflow;
    logic        overflow_clr;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_rx_packetizer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .flush        (flush),
        .pkt_data     (pkt_data),
        .pkt_wren     (pkt_wren),
        .pkt_full     (pkt_full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .idle         (idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: bytes waiting, cycles since the last restart of the idle timer.
    logic [7:0]  m_asm[$];
    int          m_age;
    logic        m_ov;
    logic        m_outv;
    logic [28:0] m_out;
    logic        m_fp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_asm.delete();
            m_age  = 0;
            m_ov   = 1'b0;
            m_outv = 1'b0;
            m_out  = '0;
            m_fp   = 1'b0;
        end else begin
            int          n;
            logic        free, hit, fl, xf;
            logic [23:0] d;
            n    = m_asm.size();
            free = !m_outv || !pkt_full;
            hit  = (m_age >= TMO) && (n == 1 || n == 2);
            fl   = (flush || m_fp) && (n == 1 || n == 2);
            xf   = free && (n == 3 || hit || fl);
            if (xf) begin
                d = '0;
                foreach (m_asm[k]) d = d | (24'(m_asm[k]) << (8 * k));
                m_out  = {1'b0, n[1:0], 2'b00, d};
                m_outv = 1'b1;
                m_asm.delete();
            end else if (m_outv && !pkt_full) begin
                m_outv = 1'b0;
            end
            if (byte_valid && m_asm.size() < 3) m_asm.push_back(byte_data);
            if (byte_valid && !xf && n == 3) m_ov = 1'b1;
            else if (overflow_clr)           m_ov = 1'b0;
            if (xf || byte_valid)            m_fp = 1'b0;
            else if (flush && n != 0)        m_fp = 1'b1;
            if (byte_valid || n == 0) m_age = 0;
            else                      m_age = m_age + 1;
        end
    end

    int          cap_t[$];
    logic [28:0] cap_d[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_wren === 1'b1) begin
                cap_t.push_back(cyc);
                cap_d.push_back(pkt_data);
            end
            check("pkt_wren", {31'd0, pkt_wren}, {31'd0, m_outv & ~pkt_full});
            check("pkt_data", {3'd0, pkt_data}, {3'd0, m_out});
            check("overflow", {31'd0, overflow}, {31'd0, m_ov});
            check("idle", {31'd0, idle}, {31'd0, (m_asm.size() == 0) && !m_outv});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic clear_cap();
        cap_t.delete();
        cap_d.delete();
    endtask

    task automatic check_cap(input string nm, input int idx, input logic [28:0] exp);
        if (cap_d.size() > idx) check(nm, {3'd0, cap_d[idx]}, {3'd0, exp});
        else                    check({nm, "_missing"}, cap_d.size(), idx + 1);
    endtask

    int t0;
    int dens;

    initial begin
        rst = 1'b1; byte_valid = 1'b0; byte_data = '0; flush = 1'b0;
        pkt_full = 1'b0; overflow_clr = 1'b0;
        #3;
        check("rst_pkt_data", {3'd0, pkt_data}, 32'd0);
        check("rst_wren", {31'd0, pkt_wren}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Three bytes: one full packet, one cycle after the third byte's edge.
        clear_cap();
        send(8'h11); send(8'h22); send(8'h33);
        t0 = cyc;
        repeat (4) tick();
        check("full_count", cap_d.size(), 1);
        check_cap("full_data", 0, 29'h0C332211);
        if (cap_t.size() > 0) check("full_latency", cap_t[0], t0 + 1);
        check("full_idle", {31'd0, idle}, 32'd1);

        // Single byte flushed by timeout.
        clear_cap();
        send(8'hA5);
        t0 = cyc;
        repeat (TMO) tick();
        check("tmo_early", cap_d.size(), 0);
        repeat (4) tick();
        check("tmo_count", cap_d.size(), 1);
        check_cap("tmo_data", 0, 29'h040000A5);
        if (cap_t.size() > 0) check("tmo_latency", cap_t[0], t0 + TMO + 1);

        // Explicit flush of two bytes, then a flush with nothing assembled.
        clear_cap();
        send(8'h01); send(8'h02);
        flush = 1'b1; tick(); t0 = cyc; flush = 1'b0;
        repeat (3) tick();
        check("flush_count", cap_d.size(), 1);
        check_cap("flush_data", 0, 29'h08000201);
        if (cap_t.size() > 0) check("flush_latency", cap_t[0], t0);
        clear_cap();
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (3) tick();
        check("flush_empty", cap_d.size(), 0);

        // Backpressure with a dropped seventh byte.
        clear_cap();
        pkt_full = 1'b1;
        for (int i = 0; i < 7; i++) send(8'h10 + 8'(i));
        check("ovf_set", {31'd0, overflow}, 32'd1);
        repeat (2) tick();
        pkt_full = 1'b0;
        repeat (4) tick();
        check("bp_count", cap_d.size(), 2);
        check_cap("bp_pkt0", 0, 29'h0C121110);
        check_cap("bp_pkt1", 1, 29'h0C151413);
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
        check("ovf_clr", {31'd0, overflow}, 32'd0);

        // Drain coinciding with a transfer plus a new byte.
        clear_cap();
        pkt_full = 1'b1;
        for (int i = 0; i < 6; i++) send(8'hC1 + 8'(i));
        tick();
        pkt_full = 1'b0;
        send(8'hC7);
        repeat (2) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (3) tick();
        check("drain_count", cap_d.size(), 3);
        check_cap("drain_pkt0", 0, 29'h0CC3C2C1);
        check_cap("drain_pkt1", 1, 29'h0CC6C5C4);
        check_cap("drain_pkt2", 2, 29'h040000C7);

        // Third byte arriving on the draining edge.
        clear_cap();
        pkt_full = 1'b1;
        send(8'hD1); send(8'hD2); send(8'hD3);
        send(8'hE1); send(8'hE2);
        pkt_full = 1'b0;
        send(8'hE3);
        repeat (4) tick();
        check("third_count", cap_d.size(), 2);
        check_cap("third_pkt0", 0, 29'h0CD3D2D1);
        check_cap("third_pkt1", 1, 29'h0CE3E2E1);

        // Asynchronous reset with a pending packet and two assembled bytes.
        clear_cap();
        pkt_full = 1'b1;
        send(8'hF1); send(8'hF2); send(8'hF3);
        send(8'hF4); send(8'hF5);
        pkt_full = 1'b0;
        #1;
        check("pre_rst_wren", {31'd0, pkt_wren}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_wren", {31'd0, pkt_wren}, 32'd0);
        check("arst_pkt_data", {3'd0, pkt_data}, 32'd0);
        check("arst_idle", {31'd0, idle}, 32'd1);
        check("arst_overflow", {31'd0, overflow}, 32'd0);
        tick();
        rst = 1'b0;
        clear_cap();
        repeat (30) tick();
        check("post_rst_count", cap_d.size(), 0);

        // Randomized traffic checked cycle by cycle against the model.
        dens = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       dens = 85;
                    1:       dens = 30;
                    default: dens = 3;
                endcase
            end
            byte_valid   = ($urandom_range(0, 99) < dens);
            byte_data    = 8'($urandom);
            flush        = !byte_valid && ($urandom_range(0, 99) < 4);
            pkt_full     = ($urandom_range(0, 99) < 30);
            overflow_clr = ($urandom_range(0, 99) < 3);
            tick();
        end
        byte_valid = 1'b0; flush = 1'b0; pkt_full = 1'b0; overflow_clr = 1'b0;
        repeat (40) tick();
        check("final_idle", {31'd0, idle}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
